// File: rtl/uart_pwm_cmd_decoder_pkg.sv
// Shared definitions for the UART -> multi-channel PWM command decoder.
//   - Protocol byte values (line feed terminator, ACK, NAK).
//   - Parser state encoding.
//   - Saturating 8-bit increment used by the error counter.
package uart_pwm_cmd_decoder_pkg;

    localparam logic [7:0] BYTE_LF  = 8'h0A;
    localparam logic [7:0] BYTE_ACK = 8'h4B;   // 'K'
    localparam logic [7:0] BYTE_NAK = 8'h45;   // 'E'

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_TERM    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_pwm_cmd_decoder_pw_scale_clamp.sv
// pw_scale_clamp: combinational payload -> pulse width conversion.
//   payload in  : raw payload in units (W_PAY bits, unsigned)
//   cycles  out : clamp(payload, UNIT_MIN, UNIT_MAX) * CYC_PER_UNIT, W_PW bits
module pw_scale_clamp #(
    parameter int UNIT_MIN     = 500,
    parameter int UNIT_MAX     = 2500,
    parameter int CYC_PER_UNIT = 27,
    parameter int W_PW         = 20,
    parameter int W_PAY        = 16
) (
    input  logic [W_PAY-1:0] payload,
    output logic [W_PW-1:0]  cycles
);

    localparam longint PROD_MAX = longint'(UNIT_MAX) * longint'(CYC_PER_UNIT);

    // The largest product must fit the output, otherwise widths silently wrap.
    generate
        if (PROD_MAX >= (longint'(1) << W_PW)) begin : g_range_check
            $error("pw_scale_clamp: UNIT_MAX*CYC_PER_UNIT does not fit in W_PW bits");
        end
    endgenerate

    logic [31:0] p32;
    logic [31:0] units;

    assign p32 = 32'(payload);

    always_comb begin
        units = p32;
        if (p32 < 32'(UNIT_MIN))
            units = 32'(UNIT_MIN);
        else if (p32 > 32'(UNIT_MAX))
            units = 32'(UNIT_MAX);
    end

    // Constant multiply; range check above guarantees no loss in truncation.
    assign cycles = W_PW'(units * 32'(CYC_PER_UNIT));

endmodule

// File: rtl/uart_pwm_cmd_decoder.sv
// uart_pwm_cmd_decoder: parses [CH][payload MSB..LSB][0x0A] frames from uart_rx,
// updates one of NUM_CH pulse-width registers and answers each frame with a
// single ACK/NAK byte towards uart_tx.
//   clk, reset_uart      : clock, synchronous active-high reset
//   rx_valid, rx_data    : received byte strobe and value
//   tx_busy              : uart_tx busy; byte is taken when tx_en && !tx_busy
//   tx_en, tx_data       : pending response request and its byte
//   pulse_width          : NUM_CH x W_PW flattened, channel c at [c*W_PW +: W_PW]
//   ch_update            : one-cycle one-hot strobe of the channel just written
//   err_count            : saturating count of rejected frames
module uart_pwm_cmd_decoder
    import uart_pwm_cmd_decoder_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int PAYLOAD_BYTES = 2,
    parameter int W_PW          = 20,
    parameter int CYC_PER_UNIT  = 27,
    parameter int UNIT_MIN      = 500,
    parameter int UNIT_MAX      = 2500,
    parameter int UNIT_DEFAULT  = 1500,
    parameter int TIMEOUT_CYC   = 270000
) (
    input  logic                   clk,
    input  logic                   reset_uart,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tx_busy,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    output logic [NUM_CH*W_PW-1:0] pulse_width,
    output logic [NUM_CH-1:0]      ch_update,
    output logic [7:0]             err_count
);

    localparam int W_PAY = PAYLOAD_BYTES * 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W_PW-1:0] PW_RESET = W_PW'(UNIT_DEFAULT * CYC_PER_UNIT);

    state_t                       state;
    logic [CH_W-1:0]              ch_q;
    logic [IDX_W-1:0]             idx;
    logic [W_PAY-1:0]             payload;
    logic [TO_W-1:0]              to_cnt;
    logic [NUM_CH-1:0][W_PW-1:0]  pw_q;
    logic [W_PW-1:0]              pw_scaled;
    logic                         ch_ok;

    assign ch_ok       = {24'd0, rx_data} < 32'(NUM_CH);
    assign pulse_width = pw_q;

    pw_scale_clamp #(
        .UNIT_MIN     (UNIT_MIN),
        .UNIT_MAX     (UNIT_MAX),
        .CYC_PER_UNIT (CYC_PER_UNIT),
        .W_PW         (W_PW),
        .W_PAY        (W_PAY)
    ) u_scale (
        .payload (payload),
        .cycles  (pw_scaled)
    );

    always_ff @(posedge clk) begin
        if (reset_uart) begin
            state     <= ST_IDLE;
            ch_q      <= '0;
            idx       <= '0;
            payload   <= '0;
            to_cnt    <= '0;
            tx_en     <= 1'b0;
            tx_data   <= 8'h00;
            ch_update <= '0;
            err_count <= 8'h00;
            for (int c = 0; c < NUM_CH; c++) pw_q[c] <= PW_RESET;
        end else begin
            ch_update <= '0;

            // Acceptance drops the request; a response queued below on the
            // same edge overrides this and is sent next (latest wins).
            if (tx_en && !tx_busy)
                tx_en <= 1'b0;

            if (rx_valid) begin
                to_cnt <= '0;
                unique case (state)
                    ST_IDLE: begin
                        if (ch_ok) begin
                            ch_q  <= CH_W'(rx_data);
                            idx   <= '0;
                            state <= ST_DATA;
                        end else if (rx_data != BYTE_LF) begin
                            state     <= ST_DISCARD;
                            err_count <= sat_inc8(err_count);
                            tx_en     <= 1'b1;
                            tx_data   <= BYTE_NAK;
                        end
                    end
                    ST_DATA: begin
                        payload <= (payload << 8) | W_PAY'(rx_data);
                        if (idx == IDX_W'(PAYLOAD_BYTES - 1))
                            state <= ST_TERM;
                        else
                            idx <= idx + 1'b1;
                    end
                    ST_TERM: begin
                        if (rx_data == BYTE_LF) begin
                            pw_q[ch_q] <= pw_scaled;
                            ch_update  <= NUM_CH'(1) << ch_q;
                            tx_en      <= 1'b1;
                            tx_data    <= BYTE_ACK;
                            state      <= ST_IDLE;
                        end else begin
                            state     <= ST_DISCARD;
                            err_count <= sat_inc8(err_count);
                            tx_en     <= 1'b1;
                            tx_data   <= BYTE_NAK;
                        end
                    end
                    ST_DISCARD: begin
                        if (rx_data == BYTE_LF)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // Fires on the TIMEOUT_CYC-th consecutive idle cycle.
                if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    to_cnt <= '0;
                    state  <= ST_IDLE;
                    if (state != ST_DISCARD) begin
                        err_count <= sat_inc8(err_count);
                        tx_en     <= 1'b1;
                        tx_data   <= BYTE_NAK;
                    end
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pwm_cmd_decoder.sv
`timescale 1ns/1ps
// Directed + randomized frame-level bench for uart_pwm_cmd_decoder.
module tb_uart_pwm_cmd_decoder;

    localparam int NUM_CH = 4;
    localparam int W_PW   = 20;
    localparam int T_OUT  = 300;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h45;

    logic                   clk = 1'b0;
    logic                   reset_uart = 1'b1;
    logic                   rx_valid = 1'b0;
    logic [7:0]             rx_data = 8'h00;
    logic                   tx_busy = 1'b0;
    logic                   tx_en;
    logic [7:0]             tx_data;
    logic [NUM_CH*W_PW-1:0] pulse_width;
    logic [NUM_CH-1:0]      ch_update;
    logic [7:0]             err_count;

    uart_pwm_cmd_decoder #(.TIMEOUT_CYC(T_OUT)) dut (
        .clk         (clk),
        .reset_uart  (reset_uart),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .pulse_width (pulse_width),
        .ch_update   (ch_update),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame-level outcome of the protocol.
    int exp_pw [NUM_CH];
    int exp_err;

    logic [7:0]        got_tx[$];
    logic [NUM_CH-1:0] upd_q[$];

    always @(negedge clk) begin
        if (!reset_uart && tx_en && !tx_busy) got_tx.push_back(tx_data);
        if (!reset_uart && ch_update != '0) upd_q.push_back(ch_update);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int clamp_cyc(input int p);
        int u;
        u = (p < 500) ? 500 : (p > 2500) ? 2500 : p;
        return u * 27;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) exp_pw[c] = 40500;
        exp_err = 0;
    endtask

    task automatic model_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("%s pw[%0d]", tag, c), 64'(pulse_width[c*W_PW +: W_PW]), 64'(exp_pw[c]));
        chk({tag, " err_count"}, 64'(err_count), 64'(exp_err));
    endtask

    // Inputs change 1 ns after a rising edge; gap = idle cycles after the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic frame_ok(input int ch, input int p, input int gap);
        send_byte(8'(ch), gap);
        send_byte(8'(p >> 8), gap);
        send_byte(8'(p & 255), gap);
        send_byte(LF, gap);
        exp_pw[ch] = clamp_cyc(p);
    endtask

    function automatic logic [7:0] non_lf(input int lo);
        logic [7:0] b;
        do b = 8'($urandom_range(lo, 255)); while (b == LF);
        return b;
    endfunction

    task automatic frame_bad_ch(input int gap);
        send_byte(non_lf(NUM_CH), gap);
        repeat ($urandom_range(0, 3)) send_byte(non_lf(0), gap);
        send_byte(LF, gap);
        model_err();
    endtask

    task automatic frame_bad_term(input int gap);
        send_byte(8'($urandom_range(0, NUM_CH - 1)), gap);
        send_byte(8'($urandom), gap);
        send_byte(8'($urandom), gap);
        send_byte(non_lf(0), gap);
        repeat ($urandom_range(0, 2)) send_byte(non_lf(0), gap);
        send_byte(LF, gap);
        model_err();
    endtask

    // Let the response drain, then compare tx bytes, update strobes and state.
    task automatic expect_resp(input string tag, input int n_tx, input logic [7:0] b, input int upd_ch);
        repeat (4) begin @(posedge clk); #1; end
        chk({tag, " tx count"}, 64'(got_tx.size()), 64'(n_tx));
        if (n_tx > 0 && got_tx.size() > 0) chk({tag, " tx byte"}, 64'(got_tx[0]), 64'(b));
        chk({tag, " upd count"}, 64'(upd_q.size()), (upd_ch >= 0) ? 64'd1 : 64'd0);
        if (upd_ch >= 0 && upd_q.size() > 0)
            chk({tag, " upd onehot"}, 64'(upd_q[0]), 64'(1 << upd_ch));
        check_state(tag);
        got_tx.delete();
        upd_q.delete();
    endtask

    function automatic int rand_payload();
        case ($urandom_range(0, 5))
            0: return 499;
            1: return 500;
            2: return 2500;
            3: return 2501;
            4: return int'($urandom_range(0, 65535));
            default: return int'($urandom_range(500, 2500));
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst tx_en", 64'(tx_en), 64'd0);
        chk("rst tx_data", 64'(tx_data), 64'd0);
        chk("rst ch_update", 64'(ch_update), 64'd0);
        reset_uart = 1'b0;
        check_state("rst");
        got_tx.delete(); upd_q.delete();

        // Basic commits
        frame_ok(2, 1500, 0);
        expect_resp("ch2 1500", 1, ACK, 2);
        frame_ok(1, 2000, 1);
        expect_resp("ch1 2000", 1, ACK, 1);

        // Clamp boundaries (payload 0x000A contains LF as data)
        frame_ok(0, 10, 0);
        expect_resp("clamp low", 1, ACK, 0);
        frame_ok(0, 65535, 0);
        expect_resp("clamp high", 1, ACK, 0);

        // Empty line is silent
        send_byte(LF, 0);
        expect_resp("empty line", 0, 8'h00, -1);

        // Bad channel, then a good frame
        send_byte(8'h07, 0); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(LF, 0);
        model_err();
        expect_resp("bad ch", 1, NAK, -1);
        frame_ok(3, 800, 0);
        expect_resp("after bad ch", 1, ACK, 3);

        // Bad terminator
        send_byte(8'h01, 0); send_byte(8'h05, 0); send_byte(8'hDC, 0); send_byte(8'h33, 0); send_byte(LF, 0);
        model_err();
        expect_resp("bad term", 1, NAK, -1);

        // Timeout in DATA, then recovery
        send_byte(8'h03, 0);
        send_byte(8'h05, T_OUT);
        model_err();
        expect_resp("timeout", 1, NAK, -1);
        frame_ok(3, 1500, 0);
        expect_resp("after timeout", 1, ACK, 3);

        // Gaps one cycle short of the timeout keep the frame alive
        frame_ok(3, 2200, T_OUT - 1);
        expect_resp("gap edge", 1, ACK, 3);

        // Timeout in DISCARD returns to IDLE silently
        send_byte(8'h07, T_OUT + 3);
        model_err();
        expect_resp("discard timeout", 1, NAK, -1);
        frame_ok(0, 1234, 0);
        expect_resp("after discard to", 1, ACK, 0);

        // Busy across several responses: only the latest is sent
        tx_busy = 1'b1;
        frame_ok(0, 1000, 0);
        frame_bad_ch(0);
        frame_ok(1, 700, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("busy tx_en", 64'(tx_en), 64'd1);
        chk("busy tx_data", 64'(tx_data), 64'(ACK));
        chk("busy upd count", 64'(upd_q.size()), 64'd2);
        upd_q.delete();
        tx_busy = 1'b0;
        expect_resp("busy release", 1, ACK, -1);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            int gap;
            int cls;
            int ch;
            int p;
            gap = $urandom_range(0, 2);
            cls = $urandom_range(0, 4);
            case (cls)
                0, 1: begin
                    ch = $urandom_range(0, NUM_CH - 1);
                    p  = rand_payload();
                    frame_ok(ch, p, gap);
                    expect_resp($sformatf("rnd%0d ok", i), 1, ACK, ch);
                end
                2: begin
                    frame_bad_ch(gap);
                    expect_resp($sformatf("rnd%0d badch", i), 1, NAK, -1);
                end
                3: begin
                    frame_bad_term(gap);
                    expect_resp($sformatf("rnd%0d badterm", i), 1, NAK, -1);
                end
                default: begin
                    send_byte(LF, gap);
                    expect_resp($sformatf("rnd%0d empty", i), 0, 8'h00, -1);
                end
            endcase
        end

        // Reset mid-frame with a response pending
        tx_busy = 1'b1;
        frame_ok(2, 2100, 0);
        send_byte(8'h01, 0);
        send_byte(8'h07, 0);
        reset_uart = 1'b1;
        @(posedge clk); #1;
        model_reset();
        chk("midrst tx_en", 64'(tx_en), 64'd0);
        chk("midrst tx_data", 64'(tx_data), 64'd0);
        chk("midrst ch_update", 64'(ch_update), 64'd0);
        check_state("midrst");
        reset_uart = 1'b0;
        tx_busy = 1'b0;
        got_tx.delete(); upd_q.delete();
        expect_resp("post rst idle", 0, 8'h00, -1);
        frame_ok(1, 2000, 0);
        expect_resp("post rst frame", 1, ACK, 1);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hFF, 0);
            send_byte(LF, 0);
            model_err();
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("sat err_count", 64'(err_count), 64'(exp_err));
        chk("sat err 255", 64'(err_count), 64'd255);
        got_tx.delete(); upd_q.delete();
        frame_ok(2, 600, 0);
        expect_resp("after sat", 1, ACK, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
